led_write_scheduler: RTL

- Sits between the CPU memory-IO write path and the 24-bit LED driver, and owns that driver's single write port.
- Passes CPU LED writes through with a fixed one-cycle latency.
- Holds a 24-bit shadow of the CPU-intended light pattern.
- Runs an autonomous blink/scroll sequencer. The sequencer issues its own LED writes only in cycles when the CPU is not writing.
- Configured by CPU writes to LED address 2'b01, which the LED driver ignores.

---
 rtl/led_write_scheduler_if.sv | 23 ++
 rtl/led_write_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_write_scheduler_if.sv
// CPU-side write bus and LED-driver-side port of the LED write scheduler.
// The master modport is the CPU/decode side, the slave modport is the scheduler.
interface led_write_scheduler_if;
  logic        iDoIOWrite;
  logic        iDoLedWrite;
  logic [1:0]  iLightAddress;
  logic [15:0] iLightDataToWrite;
  logic        oLedWrite;
  logic [1:0]  oLedAddress;
  logic [15:0] oLedData;
  logic        oSeqBusy;
  logic        oPhase;

  modport master (
    output iDoIOWrite, iDoLedWrite, iLightAddress, iLightDataToWrite,
    input  oLedWrite, oLedAddress, oLedData, oSeqBusy, oPhase
  );

  modport slave (
    input  iDoIOWrite, iDoLedWrite, iLightAddress, iLightDataToWrite,
    output oLedWrite, oLedAddress, oLedData, oSeqBusy, oPhase
  );
endinterface

// File: rtl/led_write_scheduler.sv
// LED write scheduler: owns the LED driver's single write port, forwards CPU
// LED writes with one cycle of latency, keeps a shadow of the CPU pattern and
// runs a blink/scroll sequencer that only writes in cycles the CPU leaves free.
// Address 2'b01 (ignored by the LED driver) holds the sequencer control word:
// bit0 blink enable, bit1 scroll enable, bits[15:8] step period.
module led_write_scheduler #(
  parameter int TICK_DIV = 100000,
  parameter int PERIOD_W = 8
) (
  input logic iCpuClock,
  input logic iCpuResetN,
  led_write_scheduler_if.slave bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    RST_LO,
    RST_HI
  } seqState_t;

  seqState_t state;
  seqState_t nextState;

  logic [23:0]         shadow;
  logic                ctrlBlink;
  logic                ctrlScroll;
  logic [PERIOD_W-1:0] ctrlPeriod;
  logic [TICK_W-1:0]   tickCnt;
  logic [PERIOD_W-1:0] stepCnt;
  logic                pending;
  logic                phase;
  logic                busy;

  logic        cpuWr;
  logic        ledWr;
  logic        ctrlWr;
  logic        enabled;
  logic        disableWr;
  logic        abortSeq;
  logic        tick;
  logic        step;
  logic        show;
  logic        startSeq;
  logic        seqIssue;
  logic [1:0]  seqAddr;
  logic [15:0] seqData;
  logic        unusedBits;

  // Decode the CPU write and classify it as an LED write or a control write.
  always_comb begin
    cpuWr     = bus.iDoIOWrite & bus.iDoLedWrite;
    ledWr     = cpuWr & ~bus.iLightAddress[0];
    ctrlWr    = cpuWr & (bus.iLightAddress == 2'b01);
    enabled   = ctrlBlink | ctrlScroll;
    disableWr = ctrlWr & ~bus.iLightDataToWrite[0] & ~bus.iLightDataToWrite[1];
    // Turning everything off mid-pair or with the lights blanked must restore them.
    abortSeq  = disableWr & ((state != IDLE) | ~phase);
    tick      = enabled & (tickCnt == TICK_LAST);
    step      = tick & (stepCnt == ctrlPeriod) & ~ctrlWr;
    unusedBits = ^bus.iLightDataToWrite[7:2];
  end

  // Control word register, written only through address 2'b01.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      ctrlBlink  <= 1'b0;
      ctrlScroll <= 1'b0;
      ctrlPeriod <= '0;
    end else if (ctrlWr) begin
      ctrlBlink  <= bus.iLightDataToWrite[0];
      ctrlScroll <= bus.iLightDataToWrite[1];
      ctrlPeriod <= bus.iLightDataToWrite[8 +: PERIOD_W];
    end
  end

  // Tick and step timebase; a control write restarts both so the first step
  // lands a full period after the new settings take effect.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      tickCnt <= '0;
      stepCnt <= '0;
    end else if (ctrlWr) begin
      tickCnt <= '0;
      stepCnt <= '0;
    end else if (enabled) begin
      if (tick) begin
        tickCnt <= '0;
        if (stepCnt == ctrlPeriod) begin
          stepCnt <= '0;
        end else begin
          stepCnt <= stepCnt + 1'b1;
        end
      end else begin
        tickCnt <= tickCnt + 1'b1;
      end
    end
  end

  // Single-entry step latch: a new step merges into an outstanding one, and a
  // step arriving on the same edge the sequencer starts is kept for next time.
  // A control write that disables everything drops any outstanding step.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      pending <= 1'b0;
    end else if (disableWr) begin
      pending <= 1'b0;
    end else begin
      pending <= step | (pending & ~startSeq);
    end
  end

  // Sequencer state register.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Sequencer next state and write request; any CPU write freezes the sequencer.
  always_comb begin
    nextState = state;
    startSeq  = 1'b0;
    seqIssue  = 1'b0;
    seqAddr   = 2'b00;
    seqData   = 16'h0000;
    show      = ctrlScroll | phase;
    if (abortSeq) begin
      nextState = RST_LO;
    end else if (!cpuWr) begin
      case (state)
        IDLE: begin
          if (pending && enabled) begin
            nextState = WR_LO;
            startSeq  = 1'b1;
          end
        end
        WR_LO: begin
          seqIssue  = 1'b1;
          seqAddr   = 2'b00;
          seqData   = show ? shadow[15:0] : 16'h0000;
          nextState = WR_HI;
        end
        WR_HI: begin
          seqIssue  = 1'b1;
          seqAddr   = 2'b10;
          seqData   = {8'h00, (show ? shadow[23:16] : 8'h00)};
          nextState = IDLE;
        end
        RST_LO: begin
          seqIssue  = 1'b1;
          seqAddr   = 2'b00;
          seqData   = shadow[15:0];
          nextState = RST_HI;
        end
        RST_HI: begin
          seqIssue  = 1'b1;
          seqAddr   = 2'b10;
          seqData   = {8'h00, shadow[23:16]};
          nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Shadow of the CPU pattern; scrolling rotates it left as each step starts.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      shadow <= 24'h000000;
    end else if (ledWr) begin
      if (bus.iLightAddress[1]) begin
        shadow[23:16] <= bus.iLightDataToWrite[7:0];
      end else begin
        shadow[15:0] <= bus.iLightDataToWrite;
      end
    end else if (startSeq && ctrlScroll) begin
      shadow <= {shadow[22:0], shadow[23]};
    end
  end

  // Blink phase: toggles on each blink-only step, forced back to shown on abort.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      phase <= 1'b1;
    end else if (abortSeq) begin
      phase <= 1'b1;
    end else if (startSeq && !ctrlScroll) begin
      phase <= ~phase;
    end
  end

  // Registered busy flag follows the state the sequencer is about to enter.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      busy <= 1'b0;
    end else begin
      busy <= (nextState != IDLE);
    end
  end

  // LED driver port: CPU writes win, otherwise the sequencer's write; the
  // address and data hold their last values between strobes.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      bus.oLedWrite   <= 1'b0;
      bus.oLedAddress <= 2'b00;
      bus.oLedData    <= 16'h0000;
    end else begin
      bus.oLedWrite <= ledWr | seqIssue;
      if (ledWr) begin
        bus.oLedAddress <= bus.iLightAddress;
        bus.oLedData    <= bus.iLightDataToWrite;
      end else if (seqIssue) begin
        bus.oLedAddress <= seqAddr;
        bus.oLedData    <= seqData;
      end
    end
  end

  // Status outputs straight from their registers.
  always_comb begin
    bus.oSeqBusy = busy;
    bus.oPhase   = phase;
  end

endmodule
